i2c_slave_byte_ctrl: RTL and testbench
======================================

# i2c_slave_byte_ctrl

I2C target (slave) byte controller and the responder counterpart of the team's I2C master bit controller. It filters the SCL/SDA pad inputs, detects START and STOP conditions, and matches a 7-bit own address. It receives write bytes onto a byte-valid port and fetches read bytes through a request/valid handshake. It drives SDA, and optionally SCL, open-drain through the same pad_o/padoen convention as the master.

## Interface
Parameters:
- FILTER_LEN, 3: cycles a synchronized pad input must remain stable before the filtered value changes (1..15).
- SDA_HOLD, 4: clk cycles after a filtered SCL fall before this block changes SDA (1..255).

Ports:
- clk  in  1  block clock; all state on rising edge.
- rstnn  in  1  asynchronous, active-low reset.
- enable  in  1  0 = FSM forced to IDLE, both pads released.
- own_addr  in  7  target address; sampled at every address compare.
- scl_pad_i  in  1  SCL pad input.
- scl_pad_o  out  1  tied 0.
- scl_padoen_o  out  1  0 = pull SCL low, 1 = release.
- sda_pad_i  in  1  SDA pad input.
- sda_pad_o  out  1  tied 0.
- sda_padoen_o  out  1  0 = pull SDA low, 1 = release.
- rx_data  out  8  last received write byte.
- rx_valid  out  1  one-cycle pulse; rx_data valid.
- rx_nack  in  1  sampled at the ACK phase of a received data byte; 1 = NACK that byte.
- tx_req  out  1  level; next read byte requested.
- tx_valid  in  1  with tx_req high, loads tx_data and clears tx_req.
- tx_data  in  8  read byte.
- busy  out  1  high from START to STOP.
- addressed  out  1  high from address match to the next START or STOP.
- rw  out  1  R/W bit of the last matched address.
- start_det, stop_det, master_nack  out  1  one-cycle event pulses.

## Operation
- Input path: 2-flop synchronizer, then the FILTER_LEN stability filter, then edge detection on the filtered scl and sda.
- START: sda falls while scl is high; recognized in any state, including repeated START. Effects: start_det pulse, busy=1, addressed=0, then state ADDR.
- STOP: sda rises while scl is high; recognized in any state. Effects: stop_det pulse, busy=0, addressed=0, both pads released, then state IDLE.
- Sampling: sda is shifted in MSB-first on each filtered scl rise. A 3-bit bit counter counts the bits.
- States:
  - IDLE: waits for START.
  - ADDR: after the 8th rise, compare byte[7:1] against own_addr. Address 7'h00 never matches. On match, rw=byte[0], addressed=1, go to ADDR_ACK; otherwise go to WAIT.
  - ADDR_ACK: drive SDA low for the 9th bit. Then RX if rw=0, TX if rw=1.
  - RX: after 8 bits, rx_data updates and rx_valid pulses on the same cycle as the 8th rise. Go to RX_ACK.
  - RX_ACK: SDA is driven low unless rx_nack=1, with rx_nack sampled at the 8th-rise cycle. After the 9th bit, return to RX.
  - TX: shift register drives each bit, MSB first. After 8 bits, go to TX_ACK.
  - TX_ACK: SDA released; sample the master's ACK on the 9th rise. 0 means tx_req asserts and the next state is TX. 1 means a master_nack pulse and the next state is WAIT.
  - WAIT: pads released until START or STOP.
- SDA updates, including the release after an ACK, occur SDA_HOLD cycles after a filtered scl fall. Data is never changed while scl is high.
- First read byte: tx_req asserts on the 8th-rise cycle of a read address. tx_data must be loaded before the SDA update point following ADDR_ACK.
- Loading: tx_valid without tx_req is ignored. tx_valid together with tx_req loads the shift register and clears tx_req on the next cycle.
- enable=0 mid-transfer: immediately go to IDLE, release pads, clear busy, addressed and tx_req.
- Reset values: scl_padoen_o=1, sda_padoen_o=1, rx_data=0, rx_valid=0, tx_req=0, busy=0, addressed=0, rw=0, all event pulses 0. State IDLE; filters and synchronizers reset to 1.

## Timing
- Pad to filtered signal: 2+FILTER_LEN cycles.
- Filtered event to pulse output or state change: 1 cycle.
- The SCL high and low phases must each exceed 2+FILTER_LEN+SDA_HOLD clk cycles.
- A simultaneous START/STOP and bit edge resolve to the START/STOP.

## Configuration
- I2C_SLAVE_CLK_STRETCH_EN defined:
  - If tx_req is still high at the SDA update point, the block drives scl_padoen_o=0 (SCL held low).
  - After tx_valid arrives, it loads the byte, drives SDA SDA_HOLD cycles later, then releases SCL 1 cycle after that.
  - STOP/START detection continues while stretching.
- Undefined:
  - scl_padoen_o is constant 1.
  - A missing byte transmits 8'hFF and leaves tx_req high until tx_valid or the end of the transaction.

## Test plan
- Write, own_addr=7'h50: master sends START, 0xA0, 0x3C, 0xC3, STOP -> three ACK lows on SDA; rx_valid pulses with 0x3C then 0xC3; busy returns to 0 after stop_det.
- Address mismatch, own_addr=7'h50: master sends 0xA2 -> ninth bit left high (NACK); no rx_valid; state WAIT until STOP.
- Read: master sends 0xA1; bench answers tx_req with 0x5A, then 0x96; master ACKs then NACKs -> bus carries 0x5A, 0x96; one master_nack pulse; tx_req not reasserted.
- rx_nack=1 during the second write byte -> that byte's ninth bit is high; rx_valid still pulses with the byte.
- With the macro defined, tx_valid delayed 200 cycles -> SCL held low for that period, the correct byte is shifted out afterwards, no glitch on SDA while SCL is high.
- Repeated START after a write byte, then 0xA1, then STOP mid-read -> start_det, rw=1, tx_req; stop_det releases both pads; IDLE.

Source files
------------

// File: rtl/i2c_slave_byte_ctrl.sv
// I2C target byte controller: pad filtering, START/STOP detect, 7-bit address match, RX/TX byte handshakes.
// Optional clock stretching on a late read byte is enabled by defining I2C_SLAVE_CLK_STRETCH_EN.

module i2c_slave_byte_ctrl_filt #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rstnn,
  input  logic d,
  output logic q
);
  logic [1:0] sync;
  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      sync <= 2'b11;
      q    <= 1'b1;
      cnt  <= 4'd0;
    end else begin
      sync <= {sync[0], d};
      if (sync[1] == q) cnt <= 4'd0;
      else if (cnt == 4'(FILTER_LEN - 1)) begin
        q   <= sync[1];
        cnt <= 4'd0;
      end else cnt <= cnt + 4'd1;
    end
  end
endmodule

module i2c_slave_byte_ctrl #(
  parameter int FILTER_LEN = 3,
  parameter int SDA_HOLD   = 4
) (
  input  logic       clk,
  input  logic       rstnn,
  input  logic       enable,
  input  logic [6:0] own_addr,
  input  logic       scl_pad_i,
  output logic       scl_pad_o,
  output logic       scl_padoen_o,
  input  logic       sda_pad_i,
  output logic       sda_pad_o,
  output logic       sda_padoen_o,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_nack,
  output logic       tx_req,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic       addressed,
  output logic       rw,
  output logic       start_det,
  output logic       stop_det,
  output logic       master_nack
);
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_ADDR_ACK, S_RX, S_RX_ACK, S_TX, S_TX_ACK, S_WAIT} state_t;

  logic [1:0] pad_raw, pad_flt;
  logic       scl_f, sda_f, scl_q, sda_q;
  logic       scl_rise, scl_fall, start_c, stop_c;
  state_t     state;
  logic [2:0] cnt;
  logic [6:0] sh;
  logic [7:0] sr;
  logic [7:0] hold;
  logic       nack_q;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
  logic       stretch, scl_rel;
`endif

  assign pad_raw = {sda_pad_i, scl_pad_i};
  for (genvar i = 0; i < 2; i++) begin : g_flt
    i2c_slave_byte_ctrl_filt #(.FILTER_LEN(FILTER_LEN)) u_flt (
      .clk(clk), .rstnn(rstnn), .d(pad_raw[i]), .q(pad_flt[i]));
  end

  assign scl_f     = pad_flt[0];
  assign sda_f     = pad_flt[1];
  assign scl_rise  = scl_f & ~scl_q;
  assign scl_fall  = ~scl_f & scl_q;
  // scl must be high on both samples so a bit edge never masquerades as START/STOP
  assign start_c   = scl_f & scl_q & ~sda_f & sda_q;
  assign stop_c    = scl_f & scl_q & sda_f & ~sda_q;
  assign scl_pad_o = 1'b0;
  assign sda_pad_o = 1'b0;

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state <= S_IDLE; cnt <= 3'd0; sh <= 7'd0; sr <= 8'hFF; hold <= 8'd0; nack_q <= 1'b0;
      scl_q <= 1'b1; sda_q <= 1'b1; scl_padoen_o <= 1'b1; sda_padoen_o <= 1'b1;
      rx_data <= 8'd0; rx_valid <= 1'b0; tx_req <= 1'b0; busy <= 1'b0; addressed <= 1'b0;
      rw <= 1'b0; start_det <= 1'b0; stop_det <= 1'b0; master_nack <= 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
      stretch <= 1'b0; scl_rel <= 1'b0;
`endif
    end else begin
      scl_q <= scl_f; sda_q <= sda_f;
      rx_valid <= 1'b0; start_det <= 1'b0; stop_det <= 1'b0; master_nack <= 1'b0;
      if (scl_fall) hold <= 8'(SDA_HOLD);
      else if (hold != 8'd0) hold <= hold - 8'd1;

      if (!enable || start_c || stop_c) begin
        hold <= 8'd0; sda_padoen_o <= 1'b1; scl_padoen_o <= 1'b1;
        addressed <= 1'b0; tx_req <= 1'b0; cnt <= 3'd0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
        stretch <= 1'b0; scl_rel <= 1'b0;
`endif
        if (enable && start_c) begin
          start_det <= 1'b1; busy <= 1'b1; state <= S_ADDR;
        end else begin
          stop_det <= enable; busy <= 1'b0; state <= S_IDLE;
        end
      end else begin
        if (scl_rise) begin
          if (state == S_ADDR || state == S_RX || state == S_TX) begin
            cnt <= cnt + 3'd1;
            sh  <= {sh[5:0], sda_f};
          end
          case (state)
            S_ADDR: if (cnt == 3'd7) begin
              if (sh == own_addr && own_addr != 7'd0) begin
                rw <= sda_f; addressed <= 1'b1; state <= S_ADDR_ACK;
                if (sda_f) tx_req <= 1'b1;
              end else state <= S_WAIT;
            end
            S_ADDR_ACK: begin cnt <= 3'd0; state <= rw ? S_TX : S_RX; end
            S_RX: if (cnt == 3'd7) begin
              rx_data <= {sh, sda_f}; rx_valid <= 1'b1; nack_q <= rx_nack; state <= S_RX_ACK;
            end
            S_RX_ACK: begin cnt <= 3'd0; state <= S_RX; end
            S_TX: if (cnt == 3'd7) state <= S_TX_ACK;
            S_TX_ACK: begin
              cnt <= 3'd0;
              if (!sda_f) begin tx_req <= 1'b1; state <= S_TX; end
              else begin master_nack <= 1'b1; state <= S_WAIT; end
            end
            default: ;
          endcase
        end

        // SDA only moves at the hold point after a filtered SCL fall
        if (hold == 8'd1) begin
          case (state)
            S_ADDR_ACK: sda_padoen_o <= 1'b0;
            S_RX_ACK:   sda_padoen_o <= nack_q;
            S_TX: begin
`ifdef I2C_SLAVE_CLK_STRETCH_EN
              if (tx_req) begin
                scl_padoen_o <= 1'b0; stretch <= 1'b1;
              end else begin
                sda_padoen_o <= sr[7]; sr <= {sr[6:0], 1'b1};
                if (stretch) begin stretch <= 1'b0; scl_rel <= 1'b1; end
              end
`else
              sda_padoen_o <= sr[7]; sr <= {sr[6:0], 1'b1};
`endif
            end
            default: sda_padoen_o <= 1'b1;
          endcase
        end

`ifdef I2C_SLAVE_CLK_STRETCH_EN
        if (scl_rel) begin scl_padoen_o <= 1'b1; scl_rel <= 1'b0; end
`endif
        if (tx_valid && tx_req) begin
          sr <= tx_data; tx_req <= 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
          // restart the hold timer so the late byte gets a full SDA setup before SCL is released
          if (stretch || hold == 8'd1) hold <= 8'(SDA_HOLD);
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_i2c_slave_byte_ctrl.sv
// Bench for i2c_slave_byte_ctrl: a bus-level I2C master, a tx responder and a transaction-level expectation model.
`timescale 1ns/1ps
module tb_i2c_slave_byte_ctrl;
  localparam int TQ = 15;

  logic       clk = 1'b0, rstnn = 1'b0, enable = 1'b0;
  logic [6:0] own_addr = 7'h50;
  logic       m_scl = 1'b1, m_sda = 1'b1;
  logic       scl_bus, sda_bus;
  logic       scl_pad_o, scl_padoen_o, sda_pad_o, sda_padoen_o;
  logic [7:0] rx_data, tx_data;
  logic       rx_valid, rx_nack = 1'b0, tx_req, tx_valid;
  logic       busy, addressed, rw, start_det, stop_det, master_nack;

  int checks = 0, failures = 0;
  int n_start = 0, n_stop = 0, n_mnack = 0, n_rxv = 0, n_hs = 0, stretch_cyc = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] tx_q[$];
  int tx_delay = 0;

  always #5 clk = ~clk;

  assign scl_bus = m_scl & (scl_padoen_o | scl_pad_o);
  assign sda_bus = m_sda & (sda_padoen_o | sda_pad_o);

  i2c_slave_byte_ctrl #(.FILTER_LEN(3), .SDA_HOLD(4)) dut (
    .clk(clk), .rstnn(rstnn), .enable(enable), .own_addr(own_addr),
    .scl_pad_i(scl_bus), .scl_pad_o(scl_pad_o), .scl_padoen_o(scl_padoen_o),
    .sda_pad_i(sda_bus), .sda_pad_o(sda_pad_o), .sda_padoen_o(sda_padoen_o),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_nack(rx_nack),
    .tx_req(tx_req), .tx_valid(tx_valid), .tx_data(tx_data),
    .busy(busy), .addressed(addressed), .rw(rw),
    .start_det(start_det), .stop_det(stop_det), .master_nack(master_nack));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Expected level of the ninth address bit: low only for a nonzero matching address
  function automatic logic exp_addr_ack(input logic [7:0] b, input logic [6:0] own);
    return (b[7:1] == own && own != 7'd0) ? 1'b0 : 1'b1;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_scl_high();
    int t = 0;
    while (scl_bus !== 1'b1 && t < 2000) begin cyc(1); t++; end
    if (t >= 2000) begin
      checks++; failures++;
      $display("FAIL scl_release_timeout actual=low required=high");
    end
  endtask

  task automatic m_start();
    if (!m_scl) begin m_sda = 1'b1; cyc(TQ); m_scl = 1'b1; wait_scl_high(); cyc(TQ); end
    else cyc(TQ);
    m_sda = 1'b0; cyc(TQ); m_scl = 1'b0; cyc(TQ);
  endtask

  task automatic m_stop();
    m_sda = 1'b0; cyc(TQ); m_scl = 1'b1; wait_scl_high(); cyc(TQ); m_sda = 1'b1; cyc(2*TQ);
  endtask

  task automatic m_bit(input logic b, output logic r);
    m_sda = b; cyc(TQ); m_scl = 1'b1; wait_scl_high(); cyc(TQ); r = sda_bus; cyc(TQ); m_scl = 1'b0; cyc(TQ);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) m_bit(b[i], r);
    m_bit(1'b1, ack);
  endtask

  task automatic read_byte(output logic [7:0] b, input logic ack_out);
    logic r;
    for (int i = 7; i >= 0; i--) m_bit(1'b1, b[i]);
    m_bit(ack_out, r);
  endtask

  // tx responder: answers tx_req with the next queued byte after tx_delay cycles
  initial begin
    tx_valid = 1'b0; tx_data = 8'h00;
    forever begin
      @(negedge clk);
      if (tx_req === 1'b1 && tx_q.size() > 0) begin
        repeat (tx_delay) @(negedge clk);
        if (tx_req === 1'b1) begin
          tx_data = tx_q.pop_front(); tx_valid = 1'b1; n_hs++;
          @(negedge clk);
          tx_valid = 1'b0;
        end
      end
    end
  end

  // per-cycle compare against the model
  logic prev_scl = 1'b0, prev_oe = 1'b1, prev_rxv = 1'b0;
  always @(negedge clk) begin
    if (rstnn) begin
      if (scl_bus && prev_scl) chk("sda_stable_while_scl_high", sda_padoen_o, prev_oe);
      if (rx_valid) begin
        n_rxv++;
        if (prev_rxv) chk("rx_valid_single_cycle", 1'b1, 1'b0);
        if (exp_rx.size() == 0) begin
          checks++; failures++;
          $display("FAIL rx_valid_unexpected actual=%0h required=none", rx_data);
        end else chk("rx_byte", rx_data, exp_rx.pop_front());
      end
      if (start_det) n_start++;
      if (stop_det) n_stop++;
      if (master_nack) n_mnack++;
      if (!scl_padoen_o) stretch_cyc++;
    end
    prev_scl = scl_bus; prev_oe = sda_padoen_o; prev_rxv = rx_valid;
  end

  initial begin
    logic a;
    logic [7:0] b;
    int s_start, s_stop, s_mn, s_rx, s_hs;

    cyc(5);
    chk("reset_flags", {scl_padoen_o, sda_padoen_o, rx_valid, tx_req, busy, addressed, rw,
                        start_det, stop_det, master_nack}, 10'b1100000000);
    chk("reset_rx_data", rx_data, 8'h00);
    rstnn = 1'b1; enable = 1'b1; cyc(20);

    // write 0x3C, 0xC3 to 0x50
    s_start = n_start; s_stop = n_stop; s_rx = n_rxv;
    m_start();
    chk("wr_busy_after_start", busy, 1'b1);
    chk("wr_start_pulses", n_start - s_start, 1);
    send_byte(8'hA0, a); chk("wr_addr_ack", a, exp_addr_ack(8'hA0, own_addr));
    exp_rx.push_back(8'h3C); send_byte(8'h3C, a); chk("wr_b0_ack", a, 1'b0);
    exp_rx.push_back(8'hC3); send_byte(8'hC3, a); chk("wr_b1_ack", a, 1'b0);
    chk("wr_addressed_rw", {addressed, rw}, 2'b10);
    m_stop(); cyc(10);
    chk("wr_busy_after_stop", {busy, addressed}, 2'b00);
    chk("wr_stop_pulses", n_stop - s_stop, 1);
    chk("wr_rx_count", n_rxv - s_rx, 2);
    chk("wr_rx_data_last", rx_data, 8'hC3);

    // address mismatch
    s_rx = n_rxv;
    m_start();
    send_byte(8'hA2, a); chk("mm_addr_nack", a, exp_addr_ack(8'hA2, own_addr));
    chk("mm_not_addressed", {busy, addressed}, 2'b10);
    send_byte(8'h55, a); chk("mm_wait_no_ack", a, 1'b1);
    m_stop(); cyc(10);
    chk("mm_no_rx", n_rxv - s_rx, 0);
    chk("mm_idle", busy, 1'b0);

    // read 0x5A then 0x96, master ACKs then NACKs
    s_mn = n_mnack; s_hs = n_hs;
    tx_q.push_back(8'h5A); tx_q.push_back(8'h96);
    m_start();
    send_byte(8'hA1, a); chk("rd_addr_ack", a, exp_addr_ack(8'hA1, own_addr));
    chk("rd_addressed_rw", {addressed, rw}, 2'b11);
    read_byte(b, 1'b0); chk("rd_byte0", b, 8'h5A);
    read_byte(b, 1'b1); chk("rd_byte1", b, 8'h96);
    cyc(5);
    chk("rd_master_nack", n_mnack - s_mn, 1);
    chk("rd_handshakes", n_hs - s_hs, 2);
    chk("rd_tx_req_idle", tx_req, 1'b0);
    m_stop(); cyc(10);
    chk("rd_no_extra_nack", n_mnack - s_mn, 1);

    // rx_nack on the second write byte
    m_start();
    send_byte(8'hA0, a); chk("rn_addr_ack", a, 1'b0);
    exp_rx.push_back(8'h11); send_byte(8'h11, a); chk("rn_b0_ack", a, 1'b0);
    rx_nack = 1'b1;
    exp_rx.push_back(8'h22); send_byte(8'h22, a); chk("rn_b1_nack", a, 1'b1);
    rx_nack = 1'b0;
    chk("rn_rx_data", rx_data, 8'h22);
    m_stop(); cyc(10);

`ifdef I2C_SLAVE_CLK_STRETCH_EN
    // late read byte: SCL stretched until it arrives
    tx_delay = 200; stretch_cyc = 0; tx_q.push_back(8'hA5);
    m_start();
    send_byte(8'hA1, a); chk("st_addr_ack", a, 1'b0);
    read_byte(b, 1'b1); chk("st_byte", b, 8'hA5);
    chk("st_stretched", stretch_cyc >= 50, 1'b1);
    m_stop(); cyc(10);
    tx_delay = 0;
`else
    // missing read byte goes out as 0xFF and tx_req stays up
    s_mn = n_mnack;
    m_start();
    send_byte(8'hA1, a); chk("mb_addr_ack", a, 1'b0);
    read_byte(b, 1'b1); chk("mb_byte_ff", b, 8'hFF);
    chk("mb_tx_req_held", tx_req, 1'b1);
    chk("mb_master_nack", n_mnack - s_mn, 1);
    chk("mb_scl_never_held", scl_padoen_o, 1'b1);
    m_stop(); cyc(10);
    chk("mb_tx_req_cleared", tx_req, 1'b0);
`endif

    // repeated START after a write byte, then read, STOP mid-read
    m_start();
    send_byte(8'hA0, a); chk("rs_addr_ack", a, 1'b0);
    exp_rx.push_back(8'h77); send_byte(8'h77, a); chk("rs_b0_ack", a, 1'b0);
    s_start = n_start; s_stop = n_stop; s_hs = n_hs;
    tx_q.push_back(8'hFF);
    m_start();
    chk("rs_start_pulse", n_start - s_start, 1);
    chk("rs_addr_cleared", {busy, addressed}, 2'b10);
    send_byte(8'hA1, a); chk("rs_rd_ack", a, 1'b0);
    chk("rs_rw", rw, 1'b1);
    chk("rs_tx_handshake", n_hs - s_hs, 1);
    m_stop(); cyc(10);
    chk("rs_stop_pulse", n_stop - s_stop, 1);
    chk("rs_released", {scl_padoen_o, sda_padoen_o, busy, addressed, tx_req}, 5'b11000);

    // address 0 never matches
    own_addr = 7'h00;
    m_start();
    send_byte(8'h00, a); chk("a0_nack", a, exp_addr_ack(8'h00, 7'h00));
    chk("a0_not_addressed", addressed, 1'b0);
    m_stop(); cyc(10);
    own_addr = 7'h50;

    // enable drop mid-transfer
    m_start();
    send_byte(8'hA0, a); chk("en_addr_ack", a, 1'b0);
    enable = 1'b0; cyc(2);
    chk("en_forced_idle", {busy, addressed, scl_padoen_o, sda_padoen_o, tx_req}, 5'b00110);
    m_stop(); enable = 1'b1; cyc(20);

    chk("rx_queue_drained", exp_rx.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
